// File: rtl/nes_oam_dma_pkg.sv
// Shared definitions for the sprite OAM DMA engine and the CPU bus decoder.
package nes_oam_dma_pkg;

   // DMA sequencer states. GET cycles always land on even CPU cycles.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALT  = 3'd1,
      ALIGN = 3'd2,
      GET   = 3'd3,
      PUT   = 3'd4
   } dma_state_t;

   // Register that triggers a transfer, and the OAM data port every byte is written to.
   localparam logic [15:0] DMA_REG_DEFAULT  = 16'h4014;
   localparam logic [15:0] OAM_PORT_DEFAULT = 16'h2004;

   // The eight PPU registers at $2000-$2007 repeat every 8 bytes up to $3FFF.
   localparam logic [15:0] PPU_MIRROR_MASK = 16'h2007;

   // Fold a mirrored PPU register address back onto $2000-$2007.
   function automatic logic [15:0] ppu_unmirror(input logic [15:0] addr);
      return addr & PPU_MIRROR_MASK;
   endfunction

   // True for any address inside the $2000-$3FFF PPU register window.
   function automatic logic is_ppu_reg(input logic [15:0] addr);
      return addr[15:13] == 3'b001;
   endfunction

endpackage

// File: rtl/nes_oam_dma.sv
// Sprite OAM DMA engine: snoops CPU writes to the DMA register, stalls the core
// and copies one 256-byte page to the PPU OAM data port, one byte per GET/PUT pair.
module nes_oam_dma
   import nes_oam_dma_pkg::*;
#(
   parameter logic [15:0] DMA_REG  = DMA_REG_DEFAULT,
   parameter logic [15:0] OAM_PORT = OAM_PORT_DEFAULT
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        ce,
   input  logic [15:0] cpu_address,
   input  logic [7:0]  cpu_out,
   input  logic        cpu_we,
   input  logic [7:0]  mem_in,
   output logic        halt,
   output logic        dma_active,
   output logic [15:0] dma_address,
   output logic [7:0]  dma_out,
   output logic        dma_we,
   output logic        dma_rd
);

   dma_state_t state, state_next;
   logic [7:0] page, page_next;
   logic [7:0] index, index_next;
   logic [7:0] latch;
   logic       parity;
   logic       prev_get;

   // Sequencer state, source page/index and the even/odd cycle toggle advance once per CPU cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         page   <= 8'h00;
         index  <= 8'h00;
         parity <= 1'b0;
      end else if (ce) begin
         state  <= state_next;
         page   <= page_next;
         index  <= index_next;
         parity <= ~parity;
      end
   end

   // Capture the byte that arrives on the first clock of PUT so the write data
   // stays stable when ce stretches the cycle and the bus moves to the OAM port.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         latch    <= 8'h00;
         prev_get <= 1'b0;
      end else begin
         prev_get <= (state == GET);
         if (state == PUT && prev_get) begin
            latch <= mem_in;
         end
      end
   end

   // Next-state logic; a trigger is only honoured from IDLE, so writes during a transfer are ignored.
   always_comb begin
      state_next = state;
      page_next  = page;
      index_next = index;
      case (state)
         IDLE: begin
            if (cpu_we && cpu_address == DMA_REG) begin
               state_next = HALT;
               page_next  = cpu_out;
               index_next = 8'h00;
            end
         end
         // The cycle after HALT has parity ~parity; it must be even to start a GET.
         HALT:    state_next = parity ? GET : ALIGN;
         ALIGN:   state_next = GET;
         GET:     state_next = PUT;
         PUT: begin
            if (index == 8'hFF) begin
               state_next = IDLE;
            end else begin
               index_next = index + 8'h01;
               state_next = GET;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Bus outputs decode straight from the state so reset clears them without waiting for a clock.
   always_comb begin
      halt        = (state != IDLE);
      dma_active  = (state != IDLE);
      dma_rd      = 1'b0;
      dma_we      = 1'b0;
      dma_address = 16'h0000;
      dma_out     = 8'h00;
      case (state)
         GET: begin
            dma_rd      = 1'b1;
            dma_address = {page, index};
         end
         PUT: begin
            dma_we      = 1'b1;
            dma_address = OAM_PORT;
            dma_out     = prev_get ? mem_in : latch;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_nes_oam_dma.sv
// Directed bench for nes_oam_dma: a registered memory model feeds the DMA reads,
// a scoreboard holds the expected put sequence and halt length for each transfer.
module tb_nes_oam_dma;

   typedef struct packed {
      logic [15:0] src;
      logic [7:0]  data;
   } put_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        ce = 1'b1;
   logic [15:0] cpu_address;
   logic [7:0]  cpu_out;
   logic        cpu_we;
   logic [7:0]  mem_in = 8'h00;
   logic        halt;
   logic        dma_active;
   logic [15:0] dma_address;
   logic [7:0]  dma_out;
   logic        dma_we;
   logic        dma_rd;

   logic [7:0]  mem [0:65535];
   put_t        put_q[$];
   int          halt_q[$];

   int          n_cmp = 0;
   int          n_err = 0;
   int          ce_count = 0;
   int          puts_seen = 0;
   int          hcount = 0;
   bit          ce_mode = 1'b0;
   logic [15:0] last_rd = 16'h0000;
   logic [7:0]  put253 = 8'h00;
   bit          prev_ok = 1'b0;
   bit          prev_ce = 1'b1;
   logic [27:0] prev_bus = '0;

   nes_oam_dma dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .ce          (ce),
      .cpu_address (cpu_address),
      .cpu_out     (cpu_out),
      .cpu_we      (cpu_we),
      .mem_in      (mem_in),
      .halt        (halt),
      .dma_active  (dma_active),
      .dma_address (dma_address),
      .dma_out     (dma_out),
      .dma_we      (dma_we),
      .dma_rd      (dma_rd)
   );

   always #5 clock = ~clock;

   // Registered memory: data for an address appears one clock after it is presented.
   always @(posedge clock) mem_in <= mem[dma_active ? dma_address : cpu_address];

   // CPU-cycle enable: always high, or high on every other clock when ce_mode is set.
   always @(posedge clock) begin
      #1;
      if (ce_mode) ce = ~ce;
      else         ce = 1'b1;
   end

   // Count enabled edges since reset; bit 0 is the parity of the cycle in progress.
   always @(posedge clock) begin
      if (!reset_n)  ce_count = 0;
      else if (ce)   ce_count = ce_count + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor: checks every put against the scoreboard, get parity, halt length and ce freeze.
   always @(negedge clock) begin
      put_t e;
      if (reset_n) begin
         if (ce && dma_rd) begin
            last_rd = dma_address;
            chk("get_parity", ce_count[0], 32'd0);
         end
         if (ce && dma_we) begin
            puts_seen++;
            if (puts_seen == 253) put253 = dma_out;
            chk("put_address", dma_address, 32'h2004);
            chk("put_expected", put_q.size() != 0, 32'd1);
            if (put_q.size() != 0) begin
               e = put_q.pop_front();
               chk("put_src", last_rd, e.src);
               chk("put_data", dma_out, e.data);
            end
         end
         if (halt) begin
            hcount++;
         end else if (hcount != 0) begin
            if (halt_q.size() != 0) chk("halt_len", hcount, halt_q.pop_front());
            else                    chk("halt_unexpected", hcount, 32'd0);
            hcount = 0;
         end
         if (ce_mode && prev_ok && !prev_ce)
            chk("ce_freeze", {halt, dma_active, dma_we, dma_rd, dma_out, dma_address}, prev_bus);
         prev_ok  = 1'b1;
         prev_ce  = ce;
         prev_bus = {halt, dma_active, dma_we, dma_rd, dma_out, dma_address};
      end else begin
         prev_ok = 1'b0;
      end
   end

   // Write d to a on the next enabled cycle whose parity is want (2 = any);
   // when push is set, load the scoreboard with the page copy this should start.
   task automatic issue_write(input logic [15:0] a, input logic [7:0] d, input int want, input bit push);
      bit found = 1'b0;
      for (int i = 0; i < 16 && !found; i++) begin
         @(posedge clock); #2;
         found = ce && (want == 2 || ce_count[0] == want[0]);
      end
      chk("trigger_slot", found, 32'd1);
      if (push) begin
         puts_seen = 0;
         for (int i = 0; i < 256; i++)
            put_q.push_back('{src: {d, i[7:0]}, data: mem[{d, i[7:0]}]});
         halt_q.push_back((want == 1 ? 514 : 513) * (ce_mode ? 2 : 1));
      end
      cpu_address = a;
      cpu_out     = d;
      cpu_we      = 1'b1;
      @(posedge clock); #2;
      cpu_we      = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit done = 1'b0;
      for (int i = 0; i < 2400 && !done; i++) begin
         @(negedge clock); #1;
         done = (put_q.size() == 0) && (halt_q.size() == 0) && !halt;
      end
      chk(tag, done, 32'd1);
   endtask

   task automatic wait_puts(input int n);
      bit hit = 1'b0;
      for (int i = 0; i < 1200 && !hit; i++) begin
         @(negedge clock);
         hit = (puts_seen >= n);
      end
      chk("put_progress", hit, 32'd1);
   endtask

   initial begin
      reset_n     = 1'b0;
      cpu_address = 16'h0000;
      cpu_out     = 8'h00;
      cpu_we      = 1'b0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      for (int i = 0; i < 256; i++) begin
         mem[16'h0200 + i] = i[7:0] ^ 8'h5A;
         mem[16'h0700 + i] = i[7:0] + 8'h33;
         mem[16'hFF00 + i] = i[7:0] ^ 8'hA5;
         mem[16'h0000 + i] = 8'hEE;
      end
      mem[16'hFFFC] = 8'h00;

      // Reset state
      repeat (3) @(posedge clock);
      #2;
      chk("reset_outputs", {halt, dma_active, dma_we, dma_rd, dma_out, dma_address}, 32'd0);
      @(posedge clock); #2;
      reset_n = 1'b1;
      repeat (4) @(posedge clock);

      // Page $02 copy, no ALIGN, then with ALIGN
      issue_write(16'h4014, 8'h02, 0, 1'b1);
      wait_done("basic_done");
      chk("basic_puts", puts_seen, 32'd256);
      issue_write(16'h4014, 8'h02, 1, 1'b1);
      wait_done("align_done");
      chk("align_puts", puts_seen, 32'd256);

      // Page $FF: no wrap into page $00
      issue_write(16'h4014, 8'hFF, 0, 1'b1);
      wait_done("pageff_done");
      chk("pageff_put253", put253, 32'h00);
      chk("pageff_last_rd", last_rd, 32'hFFFF);

      // Reset mid-transfer, then a fresh trigger restarts from index 0
      issue_write(16'h4014, 8'h02, 0, 1'b1);
      wait_puts(100);
      #1;
      reset_n = 1'b0;
      #1;
      chk("rst_halt", halt, 32'd0);
      chk("rst_active", dma_active, 32'd0);
      chk("rst_we", dma_we, 32'd0);
      put_q.delete();
      halt_q.delete();
      hcount = 0;
      repeat (2) @(posedge clock);
      #2;
      reset_n = 1'b1;
      repeat (5) @(negedge clock);
      chk("rst_no_resume", {halt, dma_rd, dma_we}, 32'd0);
      issue_write(16'h4014, 8'h02, 1, 1'b1);
      wait_done("restart_done");
      chk("restart_puts", puts_seen, 32'd256);

      // Retrigger with $07 during the transfer is ignored
      issue_write(16'h4014, 8'h02, 0, 1'b1);
      wait_puts(20);
      issue_write(16'h4014, 8'h07, 2, 1'b0);
      wait_done("retrig_done");
      chk("retrig_puts", puts_seen, 32'd256);

      // ce enabled on every other clock
      ce_mode = 1'b1;
      issue_write(16'h4014, 8'h02, 0, 1'b1);
      wait_done("gated_done");
      chk("gated_puts", puts_seen, 32'd256);
      issue_write(16'h4014, 8'h02, 1, 1'b1);
      wait_done("gated_align_done");
      chk("gated_align_puts", puts_seen, 32'd256);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
